hw3_sync_tx: RTL and testbench

Serial frame transmitter that produces the single-bit stream consumed by the HW3 serial sync-pattern detector. Each accepted parallel word is sent as one frame: the fixed sync pattern (default 1101101), then the data word, both MSB first, one bit per clock. The block sits upstream of the detector on the same i_clk and drives its i_data input. It supports back-to-back frames with no idle gap.

---
 rtl/hw3_sync_tx.sv | 170 +++++++++++++++++
 tb/tb_hw3_sync_tx.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/hw3_sync_tx.sv
// ---------------------------------------------------------------------------
// hw3_sync_tx
//
// Serial frame transmitter feeding the HW3 sync-pattern detector. Every word
// accepted on the parallel side goes out as one frame: SYNC_PAT first, then
// the data word, both MSB first, one bit per clock. A new word can be taken
// on the edge that ends the last data bit, so frames can be back-to-back
// with no idle gap.
//
// Ports:
//   i_clk    - clock, all state changes on the rising edge
//   i_rst    - asynchronous active-high reset; aborts any frame in flight
//   i_valid  - upstream word available
//   i_word   - payload, captured only on the accepting edge
//   o_ready  - a word is accepted on this edge if i_valid is also high
//   o_data   - serial bit stream (IDLE_BIT when no frame is in flight)
//   o_busy   - a sync or data bit is currently on o_data
//   o_sync   - o_data currently carries a sync bit
//   o_done   - one-cycle pulse during the last data bit of a frame
//
// All outputs are registered; their next values are derived from the next
// state so they line up with the bit that o_data carries.
// ---------------------------------------------------------------------------
module hw3_sync_tx #(
  parameter int                DATA_W   = 8,
  parameter int                SYNC_W   = 7,
  parameter logic [SYNC_W-1:0] SYNC_PAT = 7'b1101101,
  parameter logic              IDLE_BIT = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_word,
  output logic              o_ready,
  output logic              o_data,
  output logic              o_busy,
  output logic              o_sync,
  output logic              o_done
);

  // The counter only has to reach the longer of the two phases. A 1-bit
  // floor keeps the vector legal when both phases are a single bit long.
  localparam int MAX_W = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
  localparam int CNT_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;

  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    bitCnt_q, bitCnt_d;
  logic [DATA_W-1:0]   wordShift_q, wordShift_d;
  logic [SYNC_W-1:0]   patShift_q, patShift_d;
  logic                ready_q, ready_d;
  logic                data_q, data_d;
  logic                busy_q, busy_d;
  logic                sync_q, sync_d;
  logic                done_q, done_d;
  logic                accept;
  logic                lastDataNext;

  // A word is taken only when the registered ready flag is already high, so
  // the upstream side sees a plain valid/ready handshake on each edge.
  assign accept = ready_q & i_valid;

  // State register plus all registered outputs. Reset drops the frame at
  // once: o_data falls back to the idle level without waiting for a clock.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      bitCnt_q    <= '0;
      wordShift_q <= '0;
      patShift_q  <= '0;
      ready_q     <= 1'b0;
      data_q      <= IDLE_BIT;
      busy_q      <= 1'b0;
      sync_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bitCnt_q    <= bitCnt_d;
      wordShift_q <= wordShift_d;
      patShift_q  <= patShift_d;
      ready_q     <= ready_d;
      data_q      <= data_d;
      busy_q      <= busy_d;
      sync_q      <= sync_d;
      done_q      <= done_d;
    end
  end

  // Next-state logic. Both shift registers present their MSB as the bit to
  // send; they only shift when the counter advances inside a phase, so the
  // data MSB is still in place when the sync phase hands over. The counter
  // restarts at zero on every phase change.
  always_comb begin
    state_d     = state_q;
    bitCnt_d    = bitCnt_q;
    wordShift_d = wordShift_q;
    patShift_d  = patShift_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d     = ST_SYNC;
          bitCnt_d    = '0;
          wordShift_d = i_word;
          patShift_d  = SYNC_PAT;
        end
      end
      ST_SYNC: begin
        if (bitCnt_q == SYNC_LAST) begin
          state_d  = ST_DATA;
          bitCnt_d = '0;
        end else begin
          bitCnt_d   = bitCnt_q + CNT_W'(1);
          patShift_d = patShift_q << 1;
        end
      end
      ST_DATA: begin
        if (bitCnt_q == DATA_LAST) begin
          bitCnt_d = '0;
          if (accept) begin
            state_d     = ST_SYNC;
            wordShift_d = i_word;
            patShift_d  = SYNC_PAT;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          bitCnt_d    = bitCnt_q + CNT_W'(1);
          wordShift_d = wordShift_q << 1;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        bitCnt_d = '0;
      end
    endcase
  end

  // Output values for the coming cycle, taken from the next state and next
  // counter. Ready is offered while idle and again during the final data
  // bit, which is what allows a gapless follow-on frame.
  always_comb begin
    lastDataNext = (state_d == ST_DATA) && (bitCnt_d == DATA_LAST);
    ready_d      = (state_d == ST_IDLE) || lastDataNext;
    done_d       = lastDataNext;
    busy_d       = (state_d != ST_IDLE);
    sync_d       = (state_d == ST_SYNC);
    data_d       = IDLE_BIT;
    if (state_d == ST_SYNC) begin
      data_d = patShift_d[SYNC_W-1];
    end else if (state_d == ST_DATA) begin
      data_d = wordShift_d[DATA_W-1];
    end
  end

  assign o_ready = ready_q;
  assign o_data  = data_q;
  assign o_busy  = busy_q;
  assign o_sync  = sync_q;
  assign o_done  = done_q;

endmodule

// File: tb/tb_hw3_sync_tx.sv
// ---------------------------------------------------------------------------
// tb_hw3_sync_tx
//
// Self-checking bench for hw3_sync_tx. The stimulus side keeps its own idea
// of when the transmitter can take a word (it is free once every queued
// frame bit has been shown) and, on each accepted word, queues the whole
// expected frame: the sync pattern bits then the word bits, MSB first, the
// last one flagged as done. A monitor on the falling edge pops one entry per
// busy cycle and compares every output. A second, minimal instance
// (DATA_W=1, SYNC_W=1) covers the single-bit corner with a fixed table.
// ---------------------------------------------------------------------------
module tb_hw3_sync_tx;

  localparam int         DATA_W   = 8;
  localparam int         SYNC_W   = 7;
  localparam logic [6:0] SYNC_PAT = 7'b1101101;
  localparam logic       IDLE_BIT = 1'b0;

  typedef struct packed {
    logic bitVal;
    logic isSync;
    logic isDone;
  } expBit_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              validIn = 1'b0;
  logic [DATA_W-1:0] wordIn = '0;
  logic              readyOut, dataOut, busyOut, syncOut, doneOut;

  logic cValid = 1'b0;
  logic cWord  = 1'b0;
  logic cReady, cData, cBusy, cSync, cDone;

  expBit_t sb[$];
  expBit_t e;
  bit      armed = 1'b0;
  logic [6:0] hist = '0;
  int      findCount = 0;
  int      checks = 0;
  int      failures = 0;

  always #5 clk = ~clk;

  hw3_sync_tx #(
    .DATA_W(DATA_W), .SYNC_W(SYNC_W), .SYNC_PAT(SYNC_PAT), .IDLE_BIT(IDLE_BIT)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(validIn), .i_word(wordIn),
    .o_ready(readyOut), .o_data(dataOut), .o_busy(busyOut),
    .o_sync(syncOut), .o_done(doneOut)
  );

  hw3_sync_tx #(
    .DATA_W(1), .SYNC_W(1), .SYNC_PAT(1'b1), .IDLE_BIT(1'b0)
  ) dutCorner (
    .i_clk(clk), .i_rst(rst), .i_valid(cValid), .i_word(cWord),
    .o_ready(cReady), .o_data(cData), .o_busy(cBusy),
    .o_sync(cSync), .o_done(cDone)
  );

  // One comparison: counts it, and reports a line only when it disagrees.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Queue the full expected frame for an accepted word.
  task automatic pushFrame(input logic [DATA_W-1:0] w);
    for (int i = SYNC_W - 1; i >= 0; i--) sb.push_back('{SYNC_PAT[i], 1'b1, 1'b0});
    for (int i = DATA_W - 1; i >= 0; i--) sb.push_back('{w[i], 1'b0, (i == 0)});
  endtask

  // Advance one rising edge and update the model: the first edge after reset
  // only makes the block ready; later, a valid word is taken when nothing is
  // left to send after the current bit.
  task automatic tick();
    @(posedge clk);
    if (rst) armed = 1'b0;
    else if (!armed) armed = 1'b1;
    else if (validIn && sb.size() == 0) pushFrame(wordIn);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [DATA_W-1:0] w);
    validIn = v;
    wordIn  = w;
    tick();
  endtask

  // Monitor: one scoreboard entry per busy cycle; otherwise the line must be
  // idle. Ready is expected on the last bit of a frame and whenever idle.
  // A small sliding window over o_data stands in for the downstream detector.
  always @(negedge clk) begin
    if (rst) hist = '0;
    else begin
      hist = {hist[5:0], dataOut};
      if (hist == SYNC_PAT) findCount++;
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput("busy", busyOut, 1);
      checkOutput("data", dataOut, e.bitVal);
      checkOutput("sync", syncOut, e.isSync);
      checkOutput("done", doneOut, e.isDone);
      checkOutput("ready_frame", readyOut, (sb.size() == 0));
    end else begin
      checkOutput("idle_busy", busyOut, 0);
      checkOutput("idle_data", dataOut, IDLE_BIT);
      checkOutput("idle_sync", syncOut, 0);
      checkOutput("idle_done", doneOut, 0);
      checkOutput("idle_ready", readyOut, armed);
    end
  end

  int cExpData[4]  = '{1, 1, 1, 0};
  int cExpFlag[4]  = '{0, 1, 0, 1};

  initial begin
    $display("[TB] start");
    repeat (3) tick();
    checkOutput("reset_ready", readyOut, 0);
    checkOutput("reset_data", dataOut, IDLE_BIT);
    rst = 1'b0;

    // Single-bit corner: words 1 then 0 back-to-back.
    cValid = 1'b1;
    cWord  = 1'b1;
    tick();
    tick();
    cWord = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      checkOutput("corner_data", cData, cExpData[k]);
      checkOutput("corner_ready", cReady, cExpFlag[k]);
      checkOutput("corner_done", cDone, cExpFlag[k]);
      if (k < 3) tick();
    end
    cValid = 1'b0;
    repeat (2) tick();

    // Single frame.
    applyStimulus(1'b1, 8'hA5);
    repeat (17) applyStimulus(1'b0, 8'h00);

    // Back-to-back with valid held high.
    applyStimulus(1'b1, 8'hA5);
    repeat (15) applyStimulus(1'b1, 8'h3C);
    repeat (17) applyStimulus(1'b0, 8'h00);

    // Word changing while the block is busy must not be captured.
    applyStimulus(1'b1, 8'h00);
    repeat (2) applyStimulus(1'b0, 8'h00);
    repeat (8) applyStimulus(1'b1, 8'hFF);
    repeat (20) applyStimulus(1'b0, 8'h00);

    // Reset in the middle of a frame.
    applyStimulus(1'b1, 8'h5A);
    repeat (8) applyStimulus(1'b0, 8'h00);
    rst = 1'b1;
    #1;
    checkOutput("abort_data", dataOut, IDLE_BIT);
    checkOutput("abort_busy", busyOut, 0);
    checkOutput("abort_ready", readyOut, 0);
    checkOutput("abort_done", doneOut, 0);
    sb.delete();
    armed = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    repeat (2) applyStimulus(1'b1, 8'h81);
    repeat (17) applyStimulus(1'b0, 8'h00);

    // Loopback-style sync detection on zero payloads.
    findCount = 0;
    for (int f = 0; f < 3; f++) begin
      applyStimulus(1'b1, 8'h00);
      repeat (17) applyStimulus(1'b0, 8'h00);
    end
    checkOutput("find_count", findCount, 3);

    // Randomized traffic.
    repeat (600) applyStimulus(($urandom_range(0, 3) != 0), DATA_W'($urandom));

    // Drain whatever is still queued, with a bounded wait.
    validIn = 1'b0;
    for (int i = 0; i < 40 && sb.size() > 0; i++) tick();
    repeat (2) tick();
    checkOutput("drain", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
